// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared types and constants for the fetch queue unit
package fetch_queue_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

   typedef enum logic {
      RUN       = 1'b0,
      SLOT_WAIT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// rtl/fetch_queue_unit_fifo.sv - DEPTH-entry {pc, instr} queue with push/pop and flush (optionally keeping the head)
module fetch_fifo
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       push_i,
   input  fetch_entry_t               push_entry_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic                       keep_head_i,
   output fetch_entry_t               head_entry_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_en;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      wr_en   = 1'b0;
      if (flush_i) begin
         // Keeping the head means the delay slot survives as the only entry.
         if (keep_head_i && (count_q != '0)) begin
            tail_d  = head_q + PW'(1);
            count_d = CW'(1);
         end else begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end
      end else begin
         wr_en = push_i;
         if (push_i) tail_d = tail_q + PW'(1);
         if (pop_i)  head_d = head_q + PW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[tail_q] <= push_entry_i;
   end

   assign head_entry_o = mem_q[head_q];
   assign count_o      = count_q;
   assign empty_o      = (count_q == '0);

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - MIPS fetch stage: sequential PC issue, epoch-tagged ROM reads, delay-slot redirects
// Optional IFU_ALIGN_CHECK_EN: misaligned redirect targets set a sticky flag and stop fetch after the slot.
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_data,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        misaligned
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   saved_target_q, saved_target_d;
   logic [31:0]   inflight_pc_q;
   logic          epoch_q, inflight_q, inflight_epoch_q;
   logic [31:0]   target;
   logic          stopped, issue, pop, resp_ok;
   logic          push, flush, keep_head, fifo_empty;
   logic [CW-1:0] count;
   fetch_entry_t  head, resp_entry;

   assign target = align_pc(redirect_addr);

`ifdef IFU_ALIGN_CHECK_EN
   logic misaligned_q;
   always_ff @(posedge clk) begin
      if (reset)
         misaligned_q <= 1'b0;
      else if (redirect && (redirect_addr[1:0] != 2'b00))
         misaligned_q <= 1'b1;
   end
   assign stopped = misaligned_q;
`else
   assign stopped = 1'b0;
`endif
   assign misaligned = stopped;

   assign pop     = out_valid && out_ready;
   assign resp_ok = inflight_q && (inflight_epoch_q == epoch_q);
   assign resp_entry = '{pc: inflight_pc_q, instr: imem_data};

   // Redirect with a non-empty queue: a same-cycle pop was the slot, otherwise the head is.
   always_comb begin
      push      = resp_ok;
      flush     = 1'b0;
      keep_head = 1'b0;
      if (redirect && !fifo_empty) begin
         push      = 1'b0;
         flush     = 1'b1;
         keep_head = !pop;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:       if (redirect && fifo_empty && !resp_ok) state_d = SLOT_WAIT;
         SLOT_WAIT: if (issue) state_d = RUN;
      endcase
   end

   always_comb begin
      issue = 1'b0;
      if (!reset && !redirect && ((count + CW'(inflight_q)) < CW'(DEPTH))) begin
         case (state_q)
            RUN:       issue = !stopped;
            SLOT_WAIT: issue = 1'b1;
         endcase
      end
   end

   always_comb begin
      fetch_pc_d     = fetch_pc_q;
      saved_target_d = saved_target_q;
      if (redirect) begin
         if (state_d == SLOT_WAIT) saved_target_d = target;
         else                      fetch_pc_d     = target;
      end else if (issue) begin
         fetch_pc_d = (state_q == SLOT_WAIT) ? saved_target_q : fetch_pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q       <= RESET_PC;
         saved_target_q   <= '0;
         epoch_q          <= 1'b0;
         inflight_q       <= 1'b0;
         inflight_epoch_q <= 1'b0;
         inflight_pc_q    <= '0;
      end else begin
         fetch_pc_q       <= fetch_pc_d;
         saved_target_q   <= saved_target_d;
         epoch_q          <= epoch_q ^ redirect;
         inflight_q       <= issue;
         inflight_epoch_q <= epoch_q;
         inflight_pc_q    <= fetch_pc_q;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk),
      .reset_i      (reset),
      .push_i       (push),
      .push_entry_i (resp_entry),
      .pop_i        (pop),
      .flush_i      (flush),
      .keep_head_i  (keep_head),
      .head_entry_o (head),
      .count_o      (count),
      .empty_o      (fifo_empty)
   );

   assign imem_req  = issue;
   assign imem_addr = fetch_pc_q;
   assign out_valid = !fifo_empty;
   assign out_pc    = head.pc;
   assign out_instr = out_valid ? head.instr : NOP_WORD;

   slot_wait_no_redirect: assert property (@(posedge clk) disable iff (reset)
      !(state_q == SLOT_WAIT && redirect));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit with randomized decode stalls and redirects
module tb_fetch_queue_unit;

   localparam logic [31:0] RPC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_data;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        misaligned;

   int          total = 0;
   int          bad = 0;
   int          accepted = 0;
   int          pushed = 0;
   logic [31:0] base;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   logic        cap_req;
   logic [31:0] cap_addr;

   fetch_queue_unit dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_req      (imem_req),
      .imem_data     (imem_data),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .out_ready     (out_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .misaligned    (misaligned)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F69;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Instruction ROM: answers the cycle after a request
   initial begin
      imem_data = 32'hBAD0_BAD0;
      forever begin
         @(negedge clk);
         cap_req  = imem_req;
         cap_addr = imem_addr;
         @(posedge clk);
         #1;
         imem_data = cap_req ? rom(cap_addr) : 32'hBAD0_BAD0;
      end
   end

   // Monitor: every accepted head must be the next program-order instruction
   initial forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
         accepted++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got pc %h want none", out_pc);
         end else begin
            mon_exp = exp_q.pop_front();
            check("out_pc", out_pc, mon_exp);
            check("out_instr", out_instr, rom(mon_exp));
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      redirect = 1'b0;
      redirect_addr = '0;
      out_ready = 1'b0;
      step();
      step();
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_misaligned", 32'(misaligned), 32'd0);
      exp_q.delete();
      accepted = 0;
      pushed = 0;
      base = RPC;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic push_seq(input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
      pushed += n;
   endtask

   task automatic accept_until(input int goal, input int pct);
      int budget = 2000;
      while (accepted < goal && budget > 0) begin
         out_ready = ($urandom_range(0, 99) < pct);
         step();
         budget--;
      end
      out_ready = 1'b0;
      if (accepted < goal) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got %0d want %0d", accepted, goal);
      end
   endtask

   // n instructions up to and including the branch, then its slot, then target
   task automatic seg(input int n, input int delay, input logic [31:0] tgt, input int rdy, input int pct);
      push_seq(base, n + 1);
      accept_until(pushed - 1, pct);
      repeat (delay) step();
      redirect = 1'b1;
      redirect_addr = tgt;
      out_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy);
      step();
      redirect = 1'b0;
      out_ready = 1'b0;
      base = tgt & 32'hFFFF_FFFC;
   endtask

   task automatic tail(input int n, input int pct);
      push_seq(base, n);
      accept_until(pushed, pct);
   endtask

   function automatic logic [31:0] rnd_target();
      return 32'h0001_0000 + 32'($urandom_range(0, 4095) << 2);
   endfunction

   initial begin
      // Free-running decode: sequential PCs, one request per cycle
      do_reset();
      out_ready = 1'b1;
      push_seq(RPC, 6);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("t1_imem_req", 32'(imem_req), 32'd1);
         check("t1_imem_addr", imem_addr, RPC + 32'(4 * c));
         check("t1_out_valid", 32'(out_valid), (c >= 2) ? 32'd1 : 32'd0);
         @(posedge clk);
         #1;
      end
      accept_until(6, 100);

      // Stalled decode: fetch stops once queue plus in-flight fills DEPTH
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t2_imem_req", 32'(imem_req), (c < 4) ? 32'd1 : 32'd0);
         @(posedge clk);
         #1;
      end
      push_seq(RPC, 8);
      accept_until(8, 100);

      // Redirect with full queue and no pop: head is the slot
      do_reset();
      seg(4, 6, 32'h0000_4000, 0, 100);
      tail(4, 100);

      // Redirect while the slot pops
      do_reset();
      seg(2, 0, 32'h0000_5000, 1, 100);
      tail(4, 100);

      // Nothing queued or in flight: slot fetched at fetch_pc, then target
      do_reset();
      seg(0, 0, 32'h0000_6000, 0, 100);
      @(negedge clk);
      check("t5_slot_req", 32'(imem_req), 32'd1);
      check("t5_slot_addr", imem_addr, RPC);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t5_tgt_req", 32'(imem_req), 32'd1);
      check("t5_tgt_addr", imem_addr, 32'h0000_6000);
      @(posedge clk);
      #1;
      tail(4, 100);

      // Misaligned redirect target
      do_reset();
      seg(2, 1, 32'h0000_7002, 2, 100);
      @(negedge clk);
`ifdef IFU_ALIGN_CHECK_EN
      check("t6_misaligned", 32'(misaligned), 32'd1);
      @(posedge clk);
      #1;
      accept_until(pushed, 100);
      out_ready = 1'b1;
      repeat (8) step();
      @(negedge clk);
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_imem_req", 32'(imem_req), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
`else
      check("t6_misaligned", 32'(misaligned), 32'd0);
      @(posedge clk);
      #1;
      tail(4, 100);
`endif

      // Random sessions; each reset lands mid-operation
      for (int s = 0; s < 15; s++) begin
         int pct;
         int nseg;
         do_reset();
         pct  = int'($urandom_range(30, 100));
         nseg = int'($urandom_range(2, 6));
         seg(0, int'($urandom_range(0, 3)), rnd_target(), 2, pct);
         for (int k = 0; k < nseg; k++)
            seg(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), rnd_target(), 2, pct);
         tail(4, pct);
         repeat (int'($urandom_range(0, 4))) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
